// File: rtl/radix4_booth_mult_if.sv
// Operand/result bus of the radix-4 Booth multiplier.
// master drives start and the operands; slave drives busy, done and the product.
interface radix4_booth_mult_if #(
  parameter int unsigned WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/radix4_booth_mult.sv
// Sequential radix-4 (modified Booth) multiplier retiring one digit per clock.
// Build option: RADIX4_SIGNED_EN selects two's complement operands (default unsigned).
module radix4_booth_mult #(
  parameter int unsigned WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  radix4_booth_mult_if.slave bus
);

`ifdef RADIX4_SIGNED_EN
  localparam int unsigned BW = WIDTH;
`else
  // Two zero bits on top of b so the last digit never reads as negative.
  localparam int unsigned BW = WIDTH + 2;
`endif
  localparam int unsigned NDIG  = BW / 2;
  localparam int unsigned AW    = WIDTH + 3;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    mcand;
  logic [AW-1:0]    acc;
  logic [BW-1:0]    mplr;
  logic             bprev;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [PW-1:0]    product_q;

  logic [AW-1:0]    a_ext_c;
  logic [BW-1:0]    b_ext_c;
  logic [2:0]       trip_c;
  logic [AW-1:0]    pp_c;
  logic [AW-1:0]    sum_c;
  logic [AW-1:0]    acc_nxt_c;
  logic [BW-1:0]    mplr_nxt_c;
  logic [PW-1:0]    prod_c;
  logic             load_c;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

  // Operand extension, Booth digit selection and one add/shift step.
  always_comb begin
`ifdef RADIX4_SIGNED_EN
    a_ext_c = {{3{bus.a[WIDTH-1]}}, bus.a};
    b_ext_c = bus.b;
`else
    a_ext_c = {3'b000, bus.a};
    b_ext_c = {2'b00, bus.b};
`endif
    trip_c = {mplr[1:0], bprev};
    case (trip_c)
      3'b001, 3'b010: pp_c = mcand;
      3'b011:         pp_c = mcand << 1;
      3'b100:         pp_c = ~(mcand << 1) + AW'(1);
      3'b101, 3'b110: pp_c = ~mcand + AW'(1);
      default:        pp_c = '0;
    endcase
    sum_c      = acc + pp_c;
    acc_nxt_c  = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
    mplr_nxt_c = {sum_c[1:0], mplr[BW-1:2]};
    prod_c     = PW'({acc_nxt_c, mplr_nxt_c});
    load_c     = bus.start && (state != CALC);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      bprev     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_c) begin
        mcand  <= a_ext_c;
        mplr   <= b_ext_c;
        bprev  <= 1'b0;
        acc    <= '0;
        cnt    <= CNT_W'(NDIG - 1);
        state  <= CALC;
        busy_q <= 1'b1;
      end else begin
        case (state)
          CALC: begin
            acc   <= acc_nxt_c;
            mplr  <= mplr_nxt_c;
            bprev <= mplr[1];
            if (cnt == '0) begin
              state     <= DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              product_q <= prod_c;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_radix4_booth_mult.sv
// Self-checking bench for radix4_booth_mult (WIDTH=16), either build of RADIX4_SIGNED_EN.
module tb_radix4_booth_mult;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 2 * W;
`ifdef RADIX4_SIGNED_EN
  localparam int unsigned NDIG = W / 2;
`else
  localparam int unsigned NDIG = W / 2 + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  radix4_booth_mult_if #(.WIDTH(W)) bus ();
  radix4_booth_mult #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] sb[$];
  bit            mon_en = 1'b0;
  logic [PW-1:0] last_p = '0;

  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
`ifdef RADIX4_SIGNED_EN
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
`else
    xe = PW'(x);
    ye = PW'(y);
`endif
    return xe * ye;
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every done, and product must hold between strobes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_done observed=done expected=no_done");
        end
        if (sb.size() > 0) chk("product", bus.product, sb.pop_front());
      end else begin
        chk("product_hold", bus.product, last_p);
      end
    end
    last_p = bus.product;
  end

  // Called at the negedge of the first CALC cycle; returns on the done negedge.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    forever begin
      if (bus.done) break;
      if (bus.busy) nbusy++;
      if (lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    checks++;
    assert (bus.done) else begin
      errors++;
      $error("FAIL done_timeout observed=no_done after %0d cycles expected=done", lat);
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit chk_lat);
    int lat;
    int nbusy;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    sb.push_back(model(x, y));
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, nbusy);
    if (chk_lat) begin
      chk("latency", PW'(lat), PW'(NDIG + 1));
      chk("busy_cycles", PW'(nbusy), PW'(NDIG));
      @(negedge clk);
      chk("done_one_cycle", PW'(bus.done), PW'(0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1);
  end

  initial begin
    int            lat;
    int            nbusy;
    int            ndone;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  corner[5];

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", PW'(bus.busy), PW'(0));
    chk("reset_done", PW'(bus.done), PW'(0));
    chk("reset_product", bus.product, PW'(0));
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Basic latency and value.
    run_op(16'd3, 16'd5, 1'b1);
    chk("product_3x5", bus.product, 32'h0000_000F);

`ifdef RADIX4_SIGNED_EN
    run_op(16'd3, 16'hFFFB, 1'b1);
    chk("product_3xm5", bus.product, 32'hFFFF_FFF1);
    run_op(16'h8000, 16'h8000, 1'b0);
    chk("product_min_sq", bus.product, 32'h4000_0000);
`else
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    chk("product_max_sq", bus.product, 32'hFFFE_0001);
    run_op(16'h8000, 16'd2, 1'b1);
    chk("product_8000x2", bus.product, 32'h0001_0000);
`endif

    // start mid-CALC with other operands must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd9;
    sb.push_back(model(16'd7, 16'd9));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd200;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, nbusy);
    chk("ignored_start", bus.product, 32'd63);
    repeat (3) @(negedge clk);

    // start held through done: back-to-back with no IDLE cycle.
    bus.start = 1'b1; bus.a = 16'd11; bus.b = 16'd13;
    sb.push_back(model(16'd11, 16'd13));
    @(negedge clk);
    wait_done(lat, nbusy);
    bus.a = 16'd21; bus.b = 16'd23;
    sb.push_back(model(16'd21, 16'd23));
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", PW'(bus.busy), PW'(1));
    wait_done(lat, nbusy);
    chk("b2b_latency", PW'(lat), PW'(NDIG + 1));
    chk("b2b_product", bus.product, 32'd483);

    // Reset in the 3rd CALC cycle aborts with no done strobe.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd1234; bus.b = 16'd4321;
    sb.push_back(model(16'd1234, 16'd4321));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", PW'(bus.busy), PW'(0));
    chk("abort_done", PW'(bus.done), PW'(0));
    chk("abort_product", bus.product, PW'(0));
    @(negedge clk);
    mon_en = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", PW'(ndone), PW'(0));
    run_op(16'd1234, 16'd4321, 1'b1);

    // Corner operand grid.
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        run_op(corner[i], corner[j], 1'b0);

    // Random operands.
    for (int n = 0; n < 300; n++) begin
      x = W'($urandom());
      y = W'($urandom());
      run_op(x, y, n < 3);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", PW'(sb.size()), PW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
